// File: rtl/keypad_digit_scanner.sv
// Keypad digit buffer driving a time-multiplexed common-anode 7-segment display.
// Define DIGIT_BLANK_EN to keep positions that have not been entered dark.
module keypad_digit_scanner #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 50000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [3:0]            key_num,
    input  logic                  key_valid,
    input  logic                  clear,
    output logic [7:0]            leds,
    output logic [NUM_DIGITS-1:0] digit_en,
    output logic                  full
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CW = $clog2(NUM_DIGITS + 1);

    logic [3:0]            r_buf [NUM_DIGITS];
    logic [CW-1:0]         r_count;
    logic [PW-1:0]         r_presc;
    logic [IW-1:0]         r_idx;
    logic [7:0]            r_leds;
    logic [NUM_DIGITS-1:0] r_digit_en;

    logic                  w_tick;
    logic [IW-1:0]         w_idx_next;
    logic [3:0]            w_digit;
    logic [7:0]            w_hex;
    logic [7:0]            w_seg;

    assign w_tick     = (r_presc == PW'(SCAN_DIV - 1));
    assign w_idx_next = (r_idx == IW'(NUM_DIGITS - 1)) ? '0 : r_idx + 1'b1;
    assign w_digit    = r_buf[w_idx_next];

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_hex = 8'hFF;
        case (w_digit)
            4'h0: w_hex = 8'hC0;
            4'h1: w_hex = 8'hF9;
            4'h2: w_hex = 8'hA4;
            4'h3: w_hex = 8'hB0;
            4'h4: w_hex = 8'h99;
            4'h5: w_hex = 8'h92;
            4'h6: w_hex = 8'h82;
            4'h7: w_hex = 8'hF8;
            4'h8: w_hex = 8'h80;
            4'h9: w_hex = 8'h90;
            4'hA: w_hex = 8'h88;
            4'hB: w_hex = 8'h83;
            4'hC: w_hex = 8'hC6;
            4'hD: w_hex = 8'hA1;
            4'hE: w_hex = 8'h86;
            4'hF: w_hex = 8'h8E;
            default: w_hex = 8'hFF;
        endcase
    end

`ifdef DIGIT_BLANK_EN
    assign w_seg = (CW'(w_idx_next) >= r_count) ? 8'hFF : w_hex;
`else
    assign w_seg = w_hex;
`endif

    // NOTE: the digit buffer is reset too; it is tiny and a reset must leave no stale key behind.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_DIGITS; i++) r_buf[i] <= 4'h0;
            r_count <= '0;
        end else if (clear) begin
            for (int i = 0; i < NUM_DIGITS; i++) r_buf[i] <= 4'h0;
            r_count <= '0;
        end else if (key_valid) begin
            for (int i = NUM_DIGITS - 1; i > 0; i--) r_buf[i] <= r_buf[i-1];
            r_buf[0] <= key_num;
            if (r_count != CW'(NUM_DIGITS)) r_count <= r_count + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    // Index, digit select and segments move together on the tick edge to avoid ghosting.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_idx      <= '0;
            r_digit_en <= NUM_DIGITS'(1);
            r_leds     <= 8'hFF;
        end else if (w_tick) begin
            r_idx      <= w_idx_next;
            r_digit_en <= NUM_DIGITS'(1) << w_idx_next;
            r_leds     <= w_seg;
        end
    end

    assign leds     = r_leds;
    assign digit_en = r_digit_en;
    assign full     = (r_count == CW'(NUM_DIGITS));

endmodule

// File: tb/tb_keypad_digit_scanner.sv
// Randomized bench for keypad_digit_scanner against a queue-based display model.
// Build with DIGIT_BLANK_EN defined or not; the model follows the same macro.
module tb_keypad_digit_scanner;

    localparam int NUM_DIGITS = 4;
    localparam int SCAN_DIV   = 4;

    logic                  clk;
    logic                  reset_n;
    logic [3:0]            key_num;
    logic                  key_valid;
    logic                  clear;
    logic [7:0]            leds;
    logic [NUM_DIGITS-1:0] digit_en;
    logic                  full;

    keypad_digit_scanner #(
        .NUM_DIGITS(NUM_DIGITS),
        .SCAN_DIV  (SCAN_DIV)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .key_num  (key_num),
        .key_valid(key_valid),
        .clear    (clear),
        .leds     (leds),
        .digit_en (digit_en),
        .full     (full)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    // Model: entered digits newest-first, cycles since reset, ticks since reset.
    logic [3:0]            m_digits [$];
    int                    m_cycles;
    int                    m_ticks;
    logic [7:0]            exp_leds;
    logic [NUM_DIGITS-1:0] exp_den;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [7:0] shown(input int pos);
        logic [3:0] v;
`ifdef DIGIT_BLANK_EN
        if (pos >= m_digits.size()) return 8'hFF;
`endif
        v = (pos < m_digits.size()) ? m_digits[pos] : 4'h0;
        return seg_tab[v];
    endfunction

    task automatic model_reset();
        m_digits.delete();
        m_cycles = 0;
        m_ticks  = 0;
        exp_leds = 8'hFF;
        exp_den  = NUM_DIGITS'(1);
    endtask

    task automatic check_outputs(input string phase);
        check({phase, "_leds"}, 32'(leds), 32'(exp_leds));
        check({phase, "_digit_en"}, 32'(digit_en), 32'(exp_den));
        check({phase, "_full"}, 32'(full), 32'(m_digits.size() == NUM_DIGITS));
    endtask

    // One clock: drive inputs, let the edge happen, advance the model, compare.
    task automatic cycle(input logic [3:0] kn, input logic kv, input logic cl);
        int pos;
        key_num   = kn;
        key_valid = kv;
        clear     = cl;
        @(posedge clk);
        if ((m_cycles % SCAN_DIV) == SCAN_DIV - 1) begin
            m_ticks++;
            pos      = m_ticks % NUM_DIGITS;
            exp_den  = NUM_DIGITS'(1) << pos;
            exp_leds = shown(pos);
        end
        m_cycles++;
        if (cl) begin
            m_digits.delete();
        end else if (kv) begin
            m_digits.push_front(kn);
            if (m_digits.size() > NUM_DIGITS) void'(m_digits.pop_back());
        end
        #1;
        check_outputs("cyc");
        check("onehot", 32'($onehot(digit_en)), 32'd1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(4'h0, 1'b0, 1'b0);
    endtask

    task automatic mid_reset();
        key_valid = 1'b0;
        clear     = 1'b0;
        reset_n   = 1'b0;
        #1;
        model_reset();
        check_outputs("async_rst");
        reset_n = 1'b1;
    endtask

    initial begin
        clk       = 1'b0;
        reset_n   = 1'b0;
        key_num   = 4'h0;
        key_valid = 1'b0;
        clear     = 1'b0;
        model_reset();
        #12;
        check_outputs("reset");
        reset_n = 1'b1;

        // First tick lands on the fourth edge after release.
        idle(3);
        check("pre_tick_den", 32'(digit_en), 32'h1);
        idle(1);
        check("first_tick_den", 32'(digit_en), 32'h2);

        // Keys 1,2,3 then a full refresh.
        cycle(4'h1, 1'b1, 1'b0);
        cycle(4'h2, 1'b1, 1'b0);
        cycle(4'h3, 1'b1, 1'b0);
        idle(2 * NUM_DIGITS * SCAN_DIV);
        check("three_keys_full", 32'(full), 32'd0);

        // Async reset mid-scan, then overflow with 1..5.
        idle(2);
        mid_reset();
        for (int k = 1; k <= 5; k++) begin
            cycle(4'(k), 1'b1, 1'b0);
            if (k >= 4) check("full_after_4", 32'(full), 32'd1);
        end
        idle(2 * NUM_DIGITS * SCAN_DIV);

        // Clear beats key_valid in the same cycle.
        cycle(4'h7, 1'b1, 1'b1);
        check("clear_prio_full", 32'(full), 32'd0);
        idle(2 * NUM_DIGITS * SCAN_DIV);

        // Sweep all 16 codes through digit 0.
        for (int v = 0; v < 16; v++) begin
            cycle(4'(v), 1'b1, 1'b1);
            cycle(4'(v), 1'b1, 1'b0);
            idle(NUM_DIGITS * SCAN_DIV + 1);
        end

        // Random traffic with occasional clears and asynchronous resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                mid_reset();
            end else begin
                cycle(4'($urandom_range(0, 15)),
                      ($urandom_range(0, 4) == 0),
                      ($urandom_range(0, 39) == 0));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
